// File: rtl/branch_ctrl_pkg.sv
// Shared encodings and enumerations for the EX-stage branch/jump control unit.
package branch_ctrl_pkg;

   localparam logic [5:0] OP_SPECIAL = 6'h00;
   localparam logic [5:0] OP_REGIMM  = 6'h01;
   localparam logic [5:0] OP_J       = 6'h02;
   localparam logic [5:0] OP_JAL     = 6'h03;
   localparam logic [5:0] OP_BEQ     = 6'h04;
   localparam logic [5:0] OP_BNE     = 6'h05;
   localparam logic [5:0] OP_BLEZ    = 6'h06;
   localparam logic [5:0] OP_BGTZ    = 6'h07;

   localparam logic [5:0] FN_JR      = 6'h08;
   localparam logic [5:0] FN_JALR    = 6'h09;

   localparam logic [4:0] RT_BLTZ    = 5'h00;
   localparam logic [4:0] RT_BGEZ    = 5'h01;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      REDIRECT = 2'd1,
      FLUSH    = 2'd2
   } state_t;

   typedef enum logic [3:0] {
      BK_NONE = 4'd0,
      BK_J    = 4'd1,
      BK_JAL  = 4'd2,
      BK_JR   = 4'd3,
      BK_JALR = 4'd4,
      BK_BEQ  = 4'd5,
      BK_BNE  = 4'd6,
      BK_BLEZ = 4'd7,
      BK_BGTZ = 4'd8,
      BK_BLTZ = 4'd9,
      BK_BGEZ = 4'd10
   } br_kind_t;

endpackage

// File: rtl/branch_ctrl_unit_cond.sv
// Combinational decode of control-transfer instructions: kind, condition and target.
module branch_cond_eval
   import branch_ctrl_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int PC_W   = 32
) (
   input  logic [5:0]        in_opcode,
   input  logic [5:0]        in_funct,
   input  logic [4:0]        in_rt,
   input  logic [15:0]       in_imm16,
   input  logic [25:0]       in_target26,
   input  logic [PC_W-1:0]   in_pc,
   input  logic [DATA_W-1:0] in_rs_val,
   input  logic [DATA_W-1:0] in_rt_val,
   output logic              out_is_jump,
   output logic              out_is_branch,
   output logic              out_cond,
   output logic              out_take,
   output logic              out_link,
   output logic [PC_W-1:0]   out_target,
   output logic [PC_W-1:0]   out_link_addr
);

   br_kind_t          w_kind;
   logic [PC_W-1:0]   w_pc4;
   logic [PC_W-1:0]   w_br_off;
   logic [PC_W-1:0]   w_br_tgt;
   logic [PC_W-1:0]   w_j_tgt;
   logic [PC_W-1:0]   w_jr_tgt;
   logic              w_rs_neg;
   logic              w_rs_zero;

   assign w_pc4     = in_pc + PC_W'(4);
   assign w_br_off  = {{(PC_W-18){in_imm16[15]}}, in_imm16, 2'b00};
   assign w_br_tgt  = w_pc4 + w_br_off;
   assign w_jr_tgt  = in_rs_val[PC_W-1:0];
   assign w_rs_neg  = in_rs_val[DATA_W-1];
   assign w_rs_zero = (in_rs_val == '0);

   // Region bits above the 256 MB jump window only exist when PC_W > 28.
   generate
      if (PC_W > 28) begin : g_jhi
         assign w_j_tgt = {w_pc4[PC_W-1:28], in_target26, 2'b00};
      end else begin : g_jlo
         assign w_j_tgt = {in_target26, 2'b00};
      end
   endgenerate

   // Opcode/funct/rt decode into a single branch kind.
   always_comb begin
      w_kind = BK_NONE;
      case (in_opcode)
         OP_SPECIAL: begin
            if (in_funct == FN_JR)        w_kind = BK_JR;
            else if (in_funct == FN_JALR) w_kind = BK_JALR;
         end
         OP_REGIMM: begin
            if (in_rt == RT_BLTZ)         w_kind = BK_BLTZ;
            else if (in_rt == RT_BGEZ)    w_kind = BK_BGEZ;
         end
         OP_J:    w_kind = BK_J;
         OP_JAL:  w_kind = BK_JAL;
         OP_BEQ:  w_kind = BK_BEQ;
         OP_BNE:  w_kind = BK_BNE;
         OP_BLEZ: w_kind = BK_BLEZ;
         OP_BGTZ: w_kind = BK_BGTZ;
         default: w_kind = BK_NONE;
      endcase
   end

   // Condition, link and target selection per kind; conditions are signed on rs.
   always_comb begin
      out_is_jump   = 1'b0;
      out_is_branch = 1'b0;
      out_cond      = 1'b0;
      out_link      = 1'b0;
      out_target    = w_br_tgt;
      case (w_kind)
         BK_J:    begin out_is_jump = 1'b1; out_target = w_j_tgt; end
         BK_JAL:  begin out_is_jump = 1'b1; out_target = w_j_tgt;  out_link = 1'b1; end
         BK_JR:   begin out_is_jump = 1'b1; out_target = w_jr_tgt; end
         BK_JALR: begin out_is_jump = 1'b1; out_target = w_jr_tgt; out_link = 1'b1; end
         BK_BEQ:  begin out_is_branch = 1'b1; out_cond = (in_rs_val == in_rt_val); end
         BK_BNE:  begin out_is_branch = 1'b1; out_cond = (in_rs_val != in_rt_val); end
         BK_BLEZ: begin out_is_branch = 1'b1; out_cond = w_rs_neg | w_rs_zero; end
         BK_BGTZ: begin out_is_branch = 1'b1; out_cond = ~w_rs_neg & ~w_rs_zero; end
         BK_BLTZ: begin out_is_branch = 1'b1; out_cond = w_rs_neg; end
         BK_BGEZ: begin out_is_branch = 1'b1; out_cond = ~w_rs_neg; end
         default: ;
      endcase
   end

   assign out_take      = out_is_jump | (out_is_branch & out_cond);
   assign out_link_addr = w_pc4;

endmodule

// File: rtl/branch_ctrl_unit.sv
// EX-stage jump/branch control: redirect/flush FSM, registered target and statistics counters.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | evaluating valid, non-stalled EX instructions
// REDIRECT | out_redirect/out_flush high; held while stalled
// FLUSH    | out_flush high until the flush counter runs out
module branch_ctrl_unit
   import branch_ctrl_pkg::*;
#(
   parameter int DATA_W       = 32,
   parameter int PC_W         = 32,
   parameter int CNT_W        = 16,
   parameter int FLUSH_CYCLES = 2
) (
   input  logic              in_clk,
   input  logic              in_rst_n,
   input  logic              in_valid,
   input  logic              in_stall,
   input  logic [5:0]        in_opcode,
   input  logic [5:0]        in_funct,
   input  logic [4:0]        in_rt,
   input  logic [15:0]       in_imm16,
   input  logic [25:0]       in_target26,
   input  logic [PC_W-1:0]   in_pc,
   input  logic [DATA_W-1:0] in_rs_val,
   input  logic [DATA_W-1:0] in_rt_val,
   input  logic              in_cnt_clr,
   output logic              out_redirect,
   output logic [PC_W-1:0]   out_target,
   output logic              out_flush,
   output logic              out_link,
   output logic [PC_W-1:0]   out_link_addr,
   output logic              out_busy,
   output logic [CNT_W-1:0]  out_cnt_jump,
   output logic [CNT_W-1:0]  out_cnt_branch,
   output logic [CNT_W-1:0]  out_cnt_taken
);

   localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
   localparam logic [FC_W-1:0] FC_LOAD = FC_W'(FLUSH_CYCLES - 1);

   state_t            r_state;
   state_t            w_state_nxt;
   logic [FC_W-1:0]   r_flush_cnt;
   logic [PC_W-1:0]   r_target;
   logic [PC_W-1:0]   r_link_addr;
   logic              r_link;
   logic [CNT_W-1:0]  r_cnt_jump;
   logic [CNT_W-1:0]  r_cnt_branch;
   logic [CNT_W-1:0]  r_cnt_taken;

   logic              w_eval;
   logic              w_is_jump;
   logic              w_is_branch;
   logic              w_cond;
   logic              w_take;
   logic              w_link;
   logic [PC_W-1:0]   w_target;
   logic [PC_W-1:0]   w_link_addr;

   branch_cond_eval #(
      .DATA_W (DATA_W),
      .PC_W   (PC_W)
   ) u_cond (
      .in_opcode     (in_opcode),
      .in_funct      (in_funct),
      .in_rt         (in_rt),
      .in_imm16      (in_imm16),
      .in_target26   (in_target26),
      .in_pc         (in_pc),
      .in_rs_val     (in_rs_val),
      .in_rt_val     (in_rt_val),
      .out_is_jump   (w_is_jump),
      .out_is_branch (w_is_branch),
      .out_cond      (w_cond),
      .out_take      (w_take),
      .out_link      (w_link),
      .out_target    (w_target),
      .out_link_addr (w_link_addr)
   );

   // Instructions arriving while redirecting/flushing are on the wrong path.
   assign w_eval = (r_state == IDLE) & in_valid & ~in_stall;

   // State register.
   always_ff @(posedge in_clk or negedge in_rst_n) begin
      if (!in_rst_n) r_state <= IDLE;
      else           r_state <= w_state_nxt;
   end

   // Next-state logic; stall freezes both REDIRECT and FLUSH.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:     if (w_eval && w_take) w_state_nxt = REDIRECT;
         REDIRECT: if (!in_stall) w_state_nxt = (FLUSH_CYCLES > 1) ? FLUSH : IDLE;
         FLUSH:    if (!in_stall && (r_flush_cnt <= FC_W'(1))) w_state_nxt = IDLE;
         default:  w_state_nxt = IDLE;
      endcase
   end

   // Flush down-counter: loaded on redirect, counts remaining flush cycles.
   always_ff @(posedge in_clk or negedge in_rst_n) begin
      if (!in_rst_n) begin
         r_flush_cnt <= '0;
      end else if (r_state == IDLE && w_state_nxt == REDIRECT) begin
         r_flush_cnt <= FC_LOAD;
      end else if (r_state == FLUSH && !in_stall && r_flush_cnt != '0) begin
         r_flush_cnt <= r_flush_cnt - FC_W'(1);
      end
   end

   // Capture target and link information for the redirect cycle.
   always_ff @(posedge in_clk or negedge in_rst_n) begin
      if (!in_rst_n) begin
         r_target    <= '0;
         r_link_addr <= '0;
         r_link      <= 1'b0;
      end else if (w_eval && w_take) begin
         r_target    <= w_target;
         r_link_addr <= w_link_addr;
         r_link      <= w_link;
      end
   end

   // Saturating statistics counters; clear wins over a same-cycle increment.
   always_ff @(posedge in_clk or negedge in_rst_n) begin
      if (!in_rst_n) begin
         r_cnt_jump   <= '0;
         r_cnt_branch <= '0;
         r_cnt_taken  <= '0;
      end else if (in_cnt_clr) begin
         r_cnt_jump   <= '0;
         r_cnt_branch <= '0;
         r_cnt_taken  <= '0;
      end else if (w_eval) begin
         if (w_is_jump && r_cnt_jump != '1)
            r_cnt_jump <= r_cnt_jump + CNT_W'(1);
         if (w_is_branch && r_cnt_branch != '1)
            r_cnt_branch <= r_cnt_branch + CNT_W'(1);
         if (w_is_branch && w_cond && r_cnt_taken != '1)
            r_cnt_taken <= r_cnt_taken + CNT_W'(1);
      end
   end

   assign out_redirect   = (r_state == REDIRECT);
   assign out_flush      = (r_state != IDLE);
   assign out_busy       = (r_state != IDLE);
   assign out_link       = r_link & (r_state == REDIRECT);
   assign out_target     = r_target;
   assign out_link_addr  = r_link_addr;
   assign out_cnt_jump   = r_cnt_jump;
   assign out_cnt_branch = r_cnt_branch;
   assign out_cnt_taken  = r_cnt_taken;

endmodule

// File: tb/tb_branch_ctrl_unit.sv
// Directed bench for branch_ctrl_unit; a narrow-counter instance shares inputs for saturation.
module tb_branch_ctrl_unit;
   import branch_ctrl_pkg::*;

   logic        clk, rst_n, valid, stall, cnt_clr;
   logic [5:0]  opcode, funct;
   logic [4:0]  rt;
   logic [15:0] imm16;
   logic [25:0] tgt26;
   logic [31:0] pc, rs_val, rt_val;

   logic        redirect, flush, link, busy;
   logic [31:0] target, link_addr;
   logic [15:0] cnt_jump, cnt_branch, cnt_taken;

   logic        s_redirect, s_flush, s_link, s_busy;
   logic [31:0] s_target, s_link_addr;
   logic [1:0]  s_cnt_jump, s_cnt_branch, s_cnt_taken;

   int n_cmp = 0;
   int n_err = 0;

   branch_ctrl_unit dut (
      .in_clk(clk), .in_rst_n(rst_n), .in_valid(valid), .in_stall(stall),
      .in_opcode(opcode), .in_funct(funct), .in_rt(rt), .in_imm16(imm16),
      .in_target26(tgt26), .in_pc(pc), .in_rs_val(rs_val), .in_rt_val(rt_val),
      .in_cnt_clr(cnt_clr),
      .out_redirect(redirect), .out_target(target), .out_flush(flush),
      .out_link(link), .out_link_addr(link_addr), .out_busy(busy),
      .out_cnt_jump(cnt_jump), .out_cnt_branch(cnt_branch), .out_cnt_taken(cnt_taken)
   );

   branch_ctrl_unit #(.CNT_W(2)) dut_sat (
      .in_clk(clk), .in_rst_n(rst_n), .in_valid(valid), .in_stall(stall),
      .in_opcode(opcode), .in_funct(funct), .in_rt(rt), .in_imm16(imm16),
      .in_target26(tgt26), .in_pc(pc), .in_rs_val(rs_val), .in_rt_val(rt_val),
      .in_cnt_clr(cnt_clr),
      .out_redirect(s_redirect), .out_target(s_target), .out_flush(s_flush),
      .out_link(s_link), .out_link_addr(s_link_addr), .out_busy(s_busy),
      .out_cnt_jump(s_cnt_jump), .out_cnt_branch(s_cnt_branch), .out_cnt_taken(s_cnt_taken)
   );

   always #5 clk = ~clk;

   task automatic set_instr(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] r,
                            input logic [15:0] imm, input logic [25:0] t26,
                            input logic [31:0] p, input logic [31:0] rs, input logic [31:0] rtv);
      valid = 1'b1; opcode = op; funct = fn; rt = r; imm16 = imm;
      tgt26 = t26; pc = p; rs_val = rs; rt_val = rtv;
   endtask

   task automatic idle_in();
      valid = 1'b0; opcode = 6'h3F; funct = 6'h00; rt = 5'h00; imm16 = 16'h0;
      tgt26 = 26'h0; pc = 32'h0; rs_val = 32'h0; rt_val = 32'h0;
   endtask

   task automatic clr_counters();
      @(negedge clk); cnt_clr = 1'b1;
      @(negedge clk); cnt_clr = 1'b0;
   endtask

   task automatic wait_idle();
      int k;
      k = 0;
      while (busy && k < 8) begin
         @(negedge clk);
         k++;
      end
      n_cmp++;
      if (busy !== 1'b0) begin
         n_err++; $display("FAIL wait_idle busy still %0b after %0d cycles", busy, k);
      end
   endtask

   task automatic test_reset();
      n_cmp++;
      if ({redirect, flush, link, busy} !== 4'b0000) begin
         n_err++; $display("FAIL reset_flags got %b exp 0000", {redirect, flush, link, busy});
      end
      n_cmp++;
      if ({target, link_addr} !== 64'h0) begin
         n_err++; $display("FAIL reset_addr got %h exp 0", {target, link_addr});
      end
      n_cmp++;
      if ({cnt_jump, cnt_branch, cnt_taken} !== 48'h0) begin
         n_err++; $display("FAIL reset_cnt got %h exp 0", {cnt_jump, cnt_branch, cnt_taken});
      end
   endtask

   task automatic test_beq_taken();
      clr_counters();
      set_instr(OP_BEQ, 6'h00, 5'h00, 16'hFFFE, 26'h0, 32'h0000_1000, 32'd5, 32'd5);
      @(negedge clk); idle_in();
      n_cmp++;
      if ({redirect, flush, link} !== 3'b110) begin
         n_err++; $display("FAIL beq_flags got %b exp 110", {redirect, flush, link});
      end
      n_cmp++;
      if (target !== 32'h0000_0FFC) begin
         n_err++; $display("FAIL beq_target got %h exp 00000ffc", target);
      end
      n_cmp++;
      if ({cnt_jump, cnt_branch, cnt_taken} !== {16'd0, 16'd1, 16'd1}) begin
         n_err++; $display("FAIL beq_cnt got %h exp 000000010001", {cnt_jump, cnt_branch, cnt_taken});
      end
      @(negedge clk);
      n_cmp++;
      if ({redirect, flush} !== 2'b01) begin
         n_err++; $display("FAIL beq_flush2 got %b exp 01", {redirect, flush});
      end
      @(negedge clk);
      n_cmp++;
      if ({flush, busy} !== 2'b00) begin
         n_err++; $display("FAIL beq_done got %b exp 00", {flush, busy});
      end
   endtask

   task automatic test_bne_not_taken();
      clr_counters();
      set_instr(OP_BNE, 6'h00, 5'h00, 16'h0004, 26'h0, 32'h0000_2000, 32'd7, 32'd7);
      @(negedge clk); idle_in();
      n_cmp++;
      if ({redirect, flush, busy} !== 3'b000) begin
         n_err++; $display("FAIL bne_flags got %b exp 000", {redirect, flush, busy});
      end
      n_cmp++;
      if ({cnt_branch, cnt_taken} !== {16'd1, 16'd0}) begin
         n_err++; $display("FAIL bne_cnt got %h exp 00010000", {cnt_branch, cnt_taken});
      end
   endtask

   task automatic test_noop();
      clr_counters();
      set_instr(OP_REGIMM, 6'h00, 5'h02, 16'h0004, 26'h0, 32'h0000_2000, 32'h8000_0000, 32'd0);
      @(negedge clk);
      set_instr(OP_SPECIAL, 6'h20, 5'h00, 16'h0000, 26'h0, 32'h0000_2000, 32'h0000_4000, 32'd0);
      @(negedge clk); idle_in();
      n_cmp++;
      if ({redirect, busy, cnt_jump, cnt_branch, cnt_taken} !== 50'h0) begin
         n_err++; $display("FAIL noop got redir=%0b busy=%0b cnt=%h exp all 0", redirect, busy,
                           {cnt_jump, cnt_branch, cnt_taken});
      end
   endtask

   task automatic test_jal_ignore();
      clr_counters();
      set_instr(OP_JAL, 6'h00, 5'h00, 16'h0, 26'h0000040, 32'h1000_0000, 32'h0, 32'h0);
      @(negedge clk);
      set_instr(OP_BEQ, 6'h00, 5'h00, 16'h0010, 26'h0, 32'h0000_3000, 32'd1, 32'd1);
      n_cmp++;
      if ({redirect, link} !== 2'b11) begin
         n_err++; $display("FAIL jal_flags got %b exp 11", {redirect, link});
      end
      n_cmp++;
      if (target !== 32'h1000_0100) begin
         n_err++; $display("FAIL jal_target got %h exp 10000100", target);
      end
      n_cmp++;
      if (link_addr !== 32'h1000_0004) begin
         n_err++; $display("FAIL jal_link_addr got %h exp 10000004", link_addr);
      end
      n_cmp++;
      if (cnt_jump !== 16'd1) begin
         n_err++; $display("FAIL jal_cnt_jump got %0d exp 1", cnt_jump);
      end
      @(negedge clk);
      n_cmp++;
      if ({redirect, flush, link} !== 3'b010) begin
         n_err++; $display("FAIL jal_flush got %b exp 010", {redirect, flush, link});
      end
      @(negedge clk); idle_in();
      n_cmp++;
      if ({redirect, flush, cnt_branch} !== 18'h0) begin
         n_err++; $display("FAIL jal_ignore_a got redir=%0b flush=%0b br=%0d exp 0 0 0",
                           redirect, flush, cnt_branch);
      end
      @(negedge clk);
      n_cmp++;
      if ({redirect, busy, cnt_branch, cnt_taken} !== 34'h0) begin
         n_err++; $display("FAIL jal_ignore_b got redir=%0b busy=%0b br=%0d tk=%0d exp 0",
                           redirect, busy, cnt_branch, cnt_taken);
      end
   endtask

   task automatic test_jr_stall();
      clr_counters();
      set_instr(OP_SPECIAL, FN_JR, 5'h00, 16'h0, 26'h0, 32'h0000_5000, 32'h0040_0020, 32'h0);
      @(negedge clk); idle_in(); stall = 1'b1;
      n_cmp++;
      if ({redirect, link, target} !== {2'b10, 32'h0040_0020}) begin
         n_err++; $display("FAIL jr_first got redir=%0b link=%0b tgt=%h exp 1 0 00400020",
                           redirect, link, target);
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_cmp++;
         if ({redirect, flush} !== 2'b11) begin
            n_err++; $display("FAIL jr_hold%0d got %b exp 11", i, {redirect, flush});
         end
      end
      stall = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ({redirect, flush} !== 2'b01) begin
         n_err++; $display("FAIL jr_flush got %b exp 01", {redirect, flush});
      end
      @(negedge clk);
      n_cmp++;
      if ({busy, cnt_jump} !== {1'b0, 16'd1}) begin
         n_err++; $display("FAIL jr_done got busy=%0b jump=%0d exp 0 1", busy, cnt_jump);
      end
   endtask

   task automatic test_regimm_bounds();
      clr_counters();
      set_instr(OP_REGIMM, 6'h00, RT_BGEZ, 16'h0003, 26'h0, 32'h0000_0100, 32'h8000_0000, 32'h0);
      @(negedge clk); idle_in();
      n_cmp++;
      if ({redirect, busy} !== 2'b00) begin
         n_err++; $display("FAIL bgez_neg got %b exp 00", {redirect, busy});
      end
      set_instr(OP_REGIMM, 6'h00, RT_BLTZ, 16'h0003, 26'h0, 32'h0000_0100, 32'h8000_0000, 32'h0);
      @(negedge clk); idle_in();
      n_cmp++;
      if ({redirect, target} !== {1'b1, 32'h0000_0110}) begin
         n_err++; $display("FAIL bltz_neg got redir=%0b tgt=%h exp 1 00000110", redirect, target);
      end
      wait_idle();
      set_instr(OP_BLEZ, 6'h00, 5'h00, 16'hFFFF, 26'h0, 32'h0000_0200, 32'h0, 32'h0);
      @(negedge clk); idle_in();
      n_cmp++;
      if ({redirect, target} !== {1'b1, 32'h0000_0200}) begin
         n_err++; $display("FAIL blez_zero got redir=%0b tgt=%h exp 1 00000200", redirect, target);
      end
      wait_idle();
      set_instr(OP_BGTZ, 6'h00, 5'h00, 16'h0001, 26'h0, 32'h0000_0300, 32'h0, 32'h0);
      @(negedge clk); idle_in();
      n_cmp++;
      if ({redirect, busy} !== 2'b00) begin
         n_err++; $display("FAIL bgtz_zero got %b exp 00", {redirect, busy});
      end
      n_cmp++;
      if ({cnt_jump, cnt_branch, cnt_taken} !== {16'd0, 16'd4, 16'd2}) begin
         n_err++; $display("FAIL regimm_cnt got %h exp 000000040002", {cnt_jump, cnt_branch, cnt_taken});
      end
   endtask

   task automatic test_saturation();
      clr_counters();
      for (int i = 0; i < 5; i++) begin
         set_instr(OP_BEQ, 6'h00, 5'h00, 16'h0001, 26'h0, 32'h0000_3000, 32'h0, 32'h0);
         @(negedge clk); idle_in();
         if (i == 4) begin
            n_cmp++;
            if ({s_redirect, s_flush, s_busy, s_link} !== 4'b1110 ||
                s_target !== 32'h0000_3008 || s_link_addr !== 32'h0000_3004) begin
               n_err++; $display("FAIL sat_redirect got flags=%b tgt=%h link=%h exp 1110 00003008 00003004",
                                 {s_redirect, s_flush, s_busy, s_link}, s_target, s_link_addr);
            end
         end
         wait_idle();
      end
      n_cmp++;
      if ({cnt_branch, cnt_taken} !== {16'd5, 16'd5}) begin
         n_err++; $display("FAIL sat_wide got br=%0d tk=%0d exp 5 5", cnt_branch, cnt_taken);
      end
      n_cmp++;
      if ({s_cnt_jump, s_cnt_branch, s_cnt_taken} !== 6'b00_11_11) begin
         n_err++; $display("FAIL sat_narrow got %b exp 001111", {s_cnt_jump, s_cnt_branch, s_cnt_taken});
      end
   endtask

   task automatic test_clr_priority();
      set_instr(OP_BEQ, 6'h00, 5'h00, 16'h0001, 26'h0, 32'h0000_3000, 32'h9, 32'h9);
      cnt_clr = 1'b1;
      @(negedge clk); idle_in(); cnt_clr = 1'b0;
      n_cmp++;
      if ({cnt_jump, cnt_branch, cnt_taken, s_cnt_branch, s_cnt_taken} !== 52'h0) begin
         n_err++; $display("FAIL clr_prio got %h/%b exp 0", {cnt_jump, cnt_branch, cnt_taken},
                           {s_cnt_branch, s_cnt_taken});
      end
      n_cmp++;
      if (redirect !== 1'b1) begin
         n_err++; $display("FAIL clr_redirect got %0b exp 1", redirect);
      end
      wait_idle();
   endtask

   task automatic test_reset_mid_flush();
      set_instr(OP_J, 6'h00, 5'h00, 16'h0, 26'h0000010, 32'h0000_0000, 32'h0, 32'h0);
      @(negedge clk); idle_in();
      @(negedge clk);
      n_cmp++;
      if ({redirect, flush, busy} !== 3'b011) begin
         n_err++; $display("FAIL rst_pre got %b exp 011", {redirect, flush, busy});
      end
      #2 rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({redirect, flush, busy, link} !== 4'b0000 || target !== 32'h0) begin
         n_err++; $display("FAIL rst_mid got flags=%b tgt=%h exp 0000 0", {redirect, flush, busy, link}, target);
      end
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);
      n_cmp++;
      if ({busy, cnt_jump} !== 17'h0) begin
         n_err++; $display("FAIL rst_after got busy=%0b jump=%0d exp 0 0", busy, cnt_jump);
      end
   endtask

   initial begin
      clk = 1'b0; rst_n = 1'b0; stall = 1'b0; cnt_clr = 1'b0;
      idle_in();
      repeat (2) @(negedge clk);
      test_reset();
      rst_n = 1'b1;
      @(negedge clk);
      test_beq_taken();
      test_bne_not_taken();
      test_noop();
      test_jal_ignore();
      test_jr_stall();
      test_regimm_bounds();
      test_saturation();
      test_clr_priority();
      test_reset_mid_flush();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
